// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern_gen scheduler: FSM states, generator
// sequence length and the generator's output patterns.
package pattern_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } sched_state_t;

  localparam int unsigned SEQ_LEN = 4;

  localparam logic [2:0] P0 = 3'b001;
  localparam logic [2:0] P1 = 3'b011;
  localparam logic [2:0] P2 = 3'b100;
  localparam logic [2:0] P3 = 3'b010;

  // Generator output expected at a given step index.
  function automatic logic [2:0] pattern_at(input logic [1:0] phase);
    case (phase)
      2'd0:    pattern_at = P0;
      2'd1:    pattern_at = P1;
      2'd2:    pattern_at = P2;
      default: pattern_at = P3;
    endcase
  endfunction

endpackage

// File: rtl/pattern_rr_pick.sv
// Round-robin pick: first set request bit at or after rr_ptr, modulo N_REQ.
module pattern_rr_pick
  import pattern_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    rr_ptr,
  output logic             valid,
  output logic [PW-1:0]    idx,
  output logic [N_REQ-1:0] onehot
);

  logic [N_REQ-1:0] w_rot;
  logic [N_REQ-1:0] w_oh_rot;
  logic [PW-1:0]    w_k;
  logic [PW:0]      w_sum;
  logic             w_found;

  // Rotate so bit 0 corresponds to rr_ptr (rr_ptr < N_REQ always).
  assign w_rot = N_REQ'({req, req} >> rr_ptr);

  // Priority-encode the lowest set bit of the rotated vector.
  always_comb begin
    w_found  = 1'b0;
    w_k      = '0;
    w_oh_rot = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_rot[i] && !w_found) begin
        w_found     = 1'b1;
        w_k         = PW'(i);
        w_oh_rot[i] = 1'b1;
      end
    end
  end

  // Un-rotate: the upper half of the doubled, left-shifted one-hot is the wrapped result.
  assign onehot = N_REQ'(({w_oh_rot, w_oh_rot} << rr_ptr) >> N_REQ);
  assign w_sum  = {1'b0, w_k} + {1'b0, rr_ptr};
  assign idx    = (w_sum >= (PW+1)'(N_REQ)) ? PW'(w_sum - (PW+1)'(N_REQ)) : PW'(w_sum);
  assign valid  = w_found;

endmodule

// File: rtl/pattern_sched.sv
// Round-robin, non-preemptive scheduler sharing one pattern_gen between
// N_REQ requesters. Each grant runs BURST_LEN full sequences, then a gap.
module pattern_sched
  import pattern_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned BURST_LEN = 2,
  parameter int unsigned SEQ_LEN   = pattern_pkg::SEQ_LEN,
  parameter int unsigned GAP_CYC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic             pg_enable,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       seq_phase,
  output logic             done,
  output logic             abort,
  output logic [2:0]       done_id,
  output logic             busy
);

  localparam int unsigned TOTAL = BURST_LEN * SEQ_LEN;
  localparam int unsigned CW    = $clog2(TOTAL);
  localparam int unsigned GW    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int unsigned PW    = $clog2(N_REQ);

  sched_state_t     r_state;
  logic [CW-1:0]    r_cnt;
  logic [GW-1:0]    r_gcnt;
  logic [PW-1:0]    r_rr;
  logic [PW-1:0]    r_owner;
  logic             r_pg_en;
  logic [N_REQ-1:0] r_gnt;
  logic [1:0]       r_phase;
  logic             r_done;
  logic             r_abort;
  logic [2:0]       r_done_id;
  logic             r_busy;

  logic             w_valid;
  logic [PW-1:0]    w_idx;
  logic [N_REQ-1:0] w_onehot;
  logic [PW-1:0]    w_rr_next;
  logic             w_owner_req;

  pattern_rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req    (req),
    .rr_ptr (r_rr),
    .valid  (w_valid),
    .idx    (w_idx),
    .onehot (w_onehot)
  );

  assign w_rr_next   = (w_idx == PW'(N_REQ - 1)) ? '0 : w_idx + PW'(1);
  // r_gnt is one-hot of the owner during RUN, so masking req selects its bit.
  assign w_owner_req = |(req & r_gnt);

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_gcnt    <= '0;
      r_rr      <= '0;
      r_owner   <= '0;
      r_pg_en   <= 1'b0;
      r_gnt     <= '0;
      r_phase   <= '0;
      r_done    <= 1'b0;
      r_abort   <= 1'b0;
      r_done_id <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_state <= RUN;
            r_gnt   <= w_onehot;
            r_owner <= w_idx;
            r_rr    <= w_rr_next;
            r_pg_en <= 1'b1;
            r_cnt   <= '0;
            r_phase <= '0;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!w_owner_req || (r_cnt == CW'(TOTAL - 1))) begin
            r_abort   <= !w_owner_req;
            r_done    <= w_owner_req;
            r_done_id <= 3'(r_owner);
            r_pg_en   <= 1'b0;
            r_gnt     <= '0;
            r_phase   <= '0;
            r_gcnt    <= '0;
            r_state   <= GAP;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
            r_phase <= r_phase + 2'd1;
          end
        end
        GAP: begin
          if (r_gcnt == GW'(GAP_CYC - 1)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gcnt <= r_gcnt + GW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pg_enable = r_pg_en;
  assign gnt       = r_gnt;
  assign seq_phase = r_phase;
  assign done      = r_done;
  assign abort     = r_abort;
  assign done_id   = r_done_id;
  assign busy      = r_busy;

endmodule

// File: tb/tb_pattern_sched.sv
// Bench for pattern_sched with a behavioural pattern_gen model on pg_enable.
module tb_pattern_sched;
  import pattern_pkg::*;

  localparam int N   = 4;
  localparam int BL  = 2;
  localparam int GC  = 1;
  localparam int TOT = BL * 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req   = 4'b0000;
  logic       pg_enable, done, abort, busy;
  logic [3:0] gnt;
  logic [1:0] seq_phase;
  logic [2:0] done_id;

  int checks = 0;
  int errors = 0;

  pattern_sched #(
    .N_REQ     (N),
    .BURST_LEN (BL),
    .SEQ_LEN   (4),
    .GAP_CYC   (GC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .pg_enable (pg_enable),
    .gnt       (gnt),
    .seq_phase (seq_phase),
    .done      (done),
    .abort     (abort),
    .done_id   (done_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Generator model: steps through P0..P3 while enabled, returns to phase 0 when not.
  logic [1:0] g_ph = 2'd0;
  logic [2:0] q;
  always @(posedge clk) g_ph <= pg_enable ? g_ph + 2'd1 : 2'd0;
  assign q = pg_enable ? pattern_at(g_ph) : 3'b000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] pack(input logic pg, input logic [3:0] g, input logic [1:0] ph,
                                       input logic dn, input logic ab, input logic [2:0] id,
                                       input logic bz);
    return {pg, g, ph, dn, ab, id, bz};
  endfunction

  function automatic logic [12:0] actual();
    return {pg_enable, gnt, seq_phase, done, abort, done_id, busy};
  endfunction

  task automatic monitor();
    if (pg_enable) check("q_vs_phase", 32'(q), 32'(pattern_at(seq_phase)));
    else           check("q_in_gap", 32'(q), 32'd0);
    check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    check("done_abort_excl", 32'(done && abort), 32'd0);
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  // ---------------- table of directed vectors ----------------
  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [12:0] exp;
  } row_t;
  row_t tbl[$];

  function automatic void add(input logic rst, input logic [3:0] r, input logic pg,
                              input logic [3:0] g, input logic [1:0] ph, input logic dn,
                              input logic ab, input logic [2:0] id, input logic bz);
    row_t e;
    e.rst = rst; e.req = r; e.exp = pack(pg, g, ph, dn, ab, id, bz);
    tbl.push_back(e);
  endfunction

  function automatic void run_rows(input logic [3:0] r, input int own, input int from,
                                   input int to, input logic [2:0] id);
    for (int k = from; k <= to; k++)
      add(1'b0, r, 1'b1, 4'(1 << own), 2'(k % 4), 1'b0, 1'b0, id, 1'b1);
  endfunction

  function automatic void build_table();
    int prev;
    // single burst
    add(1'b1, 4'b0000, 0, 4'b0000, 0, 0, 0, 3'd0, 0);
    run_rows(4'b0001, 0, 0, 7, 3'd0);
    add(1'b0, 4'b0001, 0, 4'b0000, 0, 1, 0, 3'd0, 1);
    add(1'b0, 4'b0000, 0, 4'b0000, 0, 0, 0, 3'd0, 0);
    add(1'b0, 4'b0000, 0, 4'b0000, 0, 0, 0, 3'd0, 0);
    // abort after 3 enabled cycles, then restart and abort at once
    run_rows(4'b0010, 1, 0, 2, 3'd0);
    add(1'b0, 4'b0000, 0, 4'b0000, 0, 0, 1, 3'd1, 1);
    add(1'b0, 4'b0000, 0, 4'b0000, 0, 0, 0, 3'd1, 0);
    run_rows(4'b0010, 1, 0, 0, 3'd1);
    add(1'b0, 4'b0000, 0, 4'b0000, 0, 0, 1, 3'd1, 1);
    add(1'b0, 4'b0000, 0, 4'b0000, 0, 0, 0, 3'd1, 0);
    // late request during owner 0's burst
    run_rows(4'b0001, 0, 0, 1, 3'd1);
    run_rows(4'b1001, 0, 2, 7, 3'd1);
    add(1'b0, 4'b1001, 0, 4'b0000, 0, 1, 0, 3'd0, 1);
    add(1'b0, 4'b1000, 0, 4'b0000, 0, 0, 0, 3'd0, 0);
    run_rows(4'b1000, 3, 0, 7, 3'd0);
    add(1'b0, 4'b1000, 0, 4'b0000, 0, 1, 0, 3'd3, 1);
    add(1'b0, 4'b0000, 0, 4'b0000, 0, 0, 0, 3'd3, 0);
    // round robin with all requesting
    add(1'b1, 4'b0000, 0, 4'b0000, 0, 0, 0, 3'd0, 0);
    prev = 0;
    for (int n = 0; n < 5; n++) begin
      int g;
      g = n % 4;
      run_rows(4'b1111, g, 0, 7, 3'(prev));
      add(1'b0, 4'b1111, 0, 4'b0000, 0, 1, 0, 3'(g), 1);
      add(1'b0, 4'b1111, 0, 4'b0000, 0, 0, 0, 3'(g), 0);
      prev = g;
    end
  endfunction

  // ---------------- reference model for random traffic ----------------
  int   m_owner = -1;
  int   m_n     = 0;
  int   m_gap   = 0;
  int   m_rr    = 0;
  int   m_id    = 0;
  logic m_done  = 1'b0;
  logic m_abort = 1'b0;

  task automatic model_reset();
    m_owner = -1; m_n = 0; m_gap = 0; m_rr = 0; m_id = 0; m_done = 1'b0; m_abort = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r);
    m_done = 1'b0; m_abort = 1'b0;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_abort = 1'b1; m_id = m_owner; m_owner = -1; m_gap = GC;
      end else if (m_n + 1 == TOT) begin
        m_done = 1'b1; m_id = m_owner; m_owner = -1; m_gap = GC;
      end else begin
        m_n++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      for (int off = 0; off < N; off++) begin
        int p;
        p = (m_rr + off) % N;
        if (r[p] && m_owner < 0) begin
          m_owner = p; m_n = 0; m_rr = (p + 1) % N;
        end
      end
    end
  endtask

  function automatic logic [12:0] model_out();
    logic on;
    on = (m_owner >= 0);
    return pack(on, on ? 4'(1 << m_owner) : 4'b0000, on ? 2'(m_n % 4) : 2'd0,
                m_done, m_abort, 3'(m_id), on || (m_gap > 0));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    // reset taking effect mid-burst, without a clock edge
    #12;
    check("reset_state", 32'(actual()), 32'd0);
    rst_n = 1'b1;
    req   = 4'b0001;
    #45;  // t=57, inside RUN
    check("mid_burst_enable", 32'(pg_enable), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'(actual()), 32'd0);
    #4;   // t=62
    rst_n = 1'b1;
    req   = 4'b0011;
    @(negedge clk);
    check("regrant_after_reset", 32'(actual()), 32'(pack(1, 4'b0001, 0, 0, 0, 3'd0, 1)));
    req = 4'b0000;
    tick();
    check("abort_after_reset", 32'(actual()), 32'(pack(0, 4'b0000, 0, 0, 1, 3'd0, 1)));
    tick();
    tick();

    build_table();
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) begin
        rst_n = 1'b0;
        req   = 4'b0000;
        #1;
        check($sformatf("row%0d_reset", i), 32'(actual()), 32'(tbl[i].exp));
        rst_n = 1'b1;
      end else begin
        req = tbl[i].req;
        tick();
        check($sformatf("row%0d", i), 32'(actual()), 32'(tbl[i].exp));
      end
    end
    req = 4'b0000;
    tick();
    tick();

    // random traffic against the reference model
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] nr;
      nr = req;
      for (int i = 0; i < N; i++) begin
        if (nr[i]) begin
          if (m_owner == i && $urandom_range(0, 29) == 0) nr[i] = 1'b0;
          else if (m_done && m_id == i && $urandom_range(0, 1) == 0) nr[i] = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
          nr[i] = 1'b1;
        end
      end
      req = nr;
      tick();
      model_step(nr);
      check($sformatf("rand_c%0d", c), 32'(actual()), 32'(model_out()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
